// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN pooling path: data type, scheduler
// state encoding and the 2x2 window operand ordering.
package cnn_pkg;

    localparam int DATA_W = 30;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAST,
        POOL,
        WRITE,
        DONE
    } state_t;

    // Operand slots of a 2x2 window, in fetch order.
    localparam logic [1:0] OP_TL = 2'd0;
    localparam logic [1:0] OP_TR = 2'd1;
    localparam logic [1:0] OP_BL = 2'd2;
    localparam logic [1:0] OP_BR = 2'd3;

    function automatic int op_offset(input logic [1:0] k, input int in_w);
        case (k)
            OP_TL:   return 0;
            OP_TR:   return 1;
            OP_BL:   return in_w;
            OP_BR:   return in_w + 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/pool_window_sched_addr_gen.sv
// Window counters (row r, column c, operand k) and the read/write buffer
// addresses derived from them.
module pool_addr_gen
    import cnn_pkg::*;
#(
    parameter int IN_W = 24,
    parameter int IN_H = 24,
    parameter int RA_W = 10,
    parameter int WA_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            step_k,
    input  logic            advance,
    output logic [1:0]      k,
    output logic [RA_W-1:0] rd_addr,
    output logic [WA_W-1:0] wr_addr,
    output logic            last_k,
    output logic            last_window
);

    localparam int C_N    = IN_W / 2;
    localparam int R_N    = IN_H / 2;
    localparam int C_BITS = (C_N > 1) ? $clog2(C_N) : 1;
    localparam int R_BITS = (R_N > 1) ? $clog2(R_N) : 1;

    logic [C_BITS-1:0] c;
    logic [R_BITS-1:0] r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            c <= '0;
            k <= '0;
        end else if (clear) begin
            r <= '0;
            c <= '0;
            k <= '0;
        end else begin
            if (step_k) begin
                k <= k + 2'd1;
            end
            if (advance) begin
                if (c == C_BITS'(C_N - 1)) begin
                    c <= '0;
                    r <= r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end
        end
    end

    // base = 2r*IN_W + 2c, plus the operand offset inside the window
    assign rd_addr = RA_W'(r) * RA_W'(2 * IN_W) + RA_W'(c) * RA_W'(2)
                   + RA_W'(op_offset(k, IN_W));
    assign wr_addr = WA_W'(r) * WA_W'(C_N) + WA_W'(c);

    assign last_k      = (k == OP_BR);
    assign last_window = (r == R_BITS'(R_N - 1)) && (c == C_BITS'(C_N - 1));

endmodule

// File: rtl/pool_window_sched.sv
// Walks 2x2 windows over a feature map: fetches four operands, hands them to
// the max-pooling unit, and writes each pooled result to the output buffer.
module pool_window_sched
    import cnn_pkg::*;
#(
    parameter int DATA_W = 30,
    parameter int IN_W   = 24,
    parameter int IN_H   = 24,
    parameter int RA_W   = 10,
    parameter int WA_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [RA_W-1:0]          rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     pool_en,
    output logic signed [DATA_W-1:0] pool_in0,
    output logic signed [DATA_W-1:0] pool_in1,
    output logic signed [DATA_W-1:0] pool_in2,
    output logic signed [DATA_W-1:0] pool_in3,
    input  logic signed [DATA_W-1:0] pool_out,
    input  logic                     pool_done,
    output logic                     wr_en,
    output logic [WA_W-1:0]          wr_addr,
    output logic signed [DATA_W-1:0] wr_data
);

    state_t state, next_state;

    logic       clear, step_k, advance;
    logic       last_k, last_window;
    logic [1:0] k;

    logic                     cap_en;
    logic [1:0]               cap_idx;
    logic signed [DATA_W-1:0] ops [4];
    logic signed [DATA_W-1:0] wr_q;

    pool_addr_gen #(
        .IN_W (IN_W),
        .IN_H (IN_H),
        .RA_W (RA_W),
        .WA_W (WA_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .step_k      (step_k),
        .advance     (advance),
        .k           (k),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .last_k      (last_k),
        .last_window (last_window)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   if (last_k) next_state = LAST;
            LAST:    next_state = POOL;
            POOL:    if (pool_done) next_state = WRITE;
            WRITE:   next_state = last_window ? DONE : FETCH;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // abort overrides everything, including a start in the same cycle
        if (abort) begin
            next_state = IDLE;
        end
    end

    always_comb begin
        busy    = 1'b0;
        rd_en   = 1'b0;
        pool_en = 1'b0;
        wr_en   = 1'b0;
        done    = 1'b0;
        busy    = (state != IDLE);
        rd_en   = (state == FETCH);
        pool_en = (state == POOL);
        wr_en   = (state == WRITE);
        done    = (state == DONE);
        step_k  = (state == FETCH);
        advance = (state == WRITE);
        clear   = (next_state == IDLE);
    end

    // Read data lags the strobe by one cycle, so the slot index is delayed too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_en  <= 1'b0;
            cap_idx <= '0;
            wr_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                ops[i] <= '0;
            end
        end else begin
            cap_en  <= rd_en;
            cap_idx <= k;
            if (cap_en && (state == FETCH || state == LAST)) begin
                ops[cap_idx] <= rd_data;
            end
            if (state == POOL && pool_done) begin
                wr_q <= pool_out;
            end
        end
    end

    assign pool_in0 = ops[0];
    assign pool_in1 = ops[1];
    assign pool_in2 = ops[2];
    assign pool_in3 = ops[3];
    assign wr_data  = wr_q;

endmodule

// File: tb/tb_pool_window_sched.sv
// Bench for pool_window_sched on a 4x4 map: buffer model, max-pooling stub
// with programmable latency, and a raster-order reference of reads/writes.
module tb_pool_window_sched;
    import cnn_pkg::*;

    localparam int DW   = DATA_W;
    localparam int IN_W = 4;
    localparam int IN_H = 4;
    localparam int RA_W = 10;
    localparam int WA_W = 8;
    localparam int NPIX = IN_W * IN_H;
    localparam int NW   = (IN_W / 2) * (IN_H / 2);

    logic            clk;
    logic            rst;
    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [RA_W-1:0] rd_addr;
    data_t           rd_data;
    logic            pool_en;
    data_t           pool_in0, pool_in1, pool_in2, pool_in3;
    data_t           pool_out;
    logic            pool_done;
    logic            wr_en;
    logic [WA_W-1:0] wr_addr;
    data_t           wr_data;

    pool_window_sched #(
        .DATA_W (DW),
        .IN_W   (IN_W),
        .IN_H   (IN_H),
        .RA_W   (RA_W),
        .WA_W   (WA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .pool_en   (pool_en),
        .pool_in0  (pool_in0),
        .pool_in1  (pool_in1),
        .pool_in2  (pool_in2),
        .pool_in3  (pool_in3),
        .pool_out  (pool_out),
        .pool_done (pool_done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // clock / reset block
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // input buffer: one-cycle read latency
    data_t mem [NPIX];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[3:0]];

    // pooling stub: max of the four operands after pool_delay wait cycles
    int pool_delay = 0;
    int pool_wait  = 0;
    always @(posedge clk) pool_wait <= pool_en ? pool_wait + 1 : 0;
    assign pool_done = pool_en && (pool_wait >= pool_delay);

    function automatic data_t max4(input data_t a, input data_t b, input data_t c, input data_t d);
        data_t m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    assign pool_out = max4(pool_in0, pool_in1, pool_in2, pool_in3);

    // scoreboard
    int n_checks = 0;
    int n_errors = 0;
    logic [RA_W-1:0] exp_rd_q[$];
    data_t           exp_wr_q[$];
    data_t           exp_ops [NW][4];

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference: raster windows, operands TL,TR,BL,BR, output = max
    task automatic build_model();
        exp_rd_q.delete();
        exp_wr_q.delete();
        for (int w = 0; w < NW; w++) begin
            int r, c, base, a;
            r    = w / (IN_W / 2);
            c    = w % (IN_W / 2);
            base = 2 * r * IN_W + 2 * c;
            for (int j = 0; j < 4; j++) begin
                a = base + (j % 2) + (j / 2) * IN_W;
                exp_rd_q.push_back(RA_W'(a));
                exp_ops[w][j] = mem[a];
            end
            exp_wr_q.push_back(max4(exp_ops[w][0], exp_ops[w][1], exp_ops[w][2], exp_ops[w][3]));
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) mem[i] = data_t'($urandom());
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"},    busy,    0);
        check_val({tag, "_done"},    done,    0);
        check_val({tag, "_rd_en"},   rd_en,   0);
        check_val({tag, "_pool_en"}, pool_en, 0);
        check_val({tag, "_wr_en"},   wr_en,   0);
        check_val({tag, "_rd_addr"}, rd_addr, 0);
        check_val({tag, "_wr_addr"}, wr_addr, 0);
        check_val({tag, "_wr_data"}, wr_data, 0);
        check_val({tag, "_pool_in"}, pool_in0 | pool_in1 | pool_in2 | pool_in3, 0);
    endtask

    // mode 0: plain run; 1: extra start during window 1 FETCH;
    // 2: abort in first POOL cycle of window 2; 3: async reset in WRITE of window tgt
    task automatic run_map(input int delay, input int mode, input int tgt);
        int start_cyc, rel, busy_cnt, wr_cnt, done_cnt, pool_run, stray;
        logic finished, abort_sent;
        busy_cnt = 0; wr_cnt = 0; done_cnt = 0; pool_run = 0;
        finished = 1'b0; abort_sent = 1'b0;
        pool_delay = delay;
        build_model();
        @(negedge clk);
        start_cyc = cyc;
        start = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            rel = cyc - start_cyc;
            if (abort_sent) begin
                check_val("abort_busy", busy, 0);
                check_val("abort_pool_en", pool_en, 0);
                stray = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (wr_en || done || busy) stray++;
                end
                check_val("abort_quiet", stray, 0);
                return;
            end
            if (busy) busy_cnt++;
            if (rd_en) begin
                if (exp_rd_q.size() == 0) check_val("rd_extra", 1, 0);
                else check_val("rd_addr", rd_addr, exp_rd_q.pop_front());
            end
            if (pool_en) begin
                pool_run++;
                check_val("pool_excl", rd_en | wr_en, 0);
                if (wr_cnt < NW) begin
                    check_val("pool_in0", pool_in0, exp_ops[wr_cnt][0]);
                    check_val("pool_in1", pool_in1, exp_ops[wr_cnt][1]);
                    check_val("pool_in2", pool_in2, exp_ops[wr_cnt][2]);
                    check_val("pool_in3", pool_in3, exp_ops[wr_cnt][3]);
                end
            end else if (pool_run > 0) begin
                check_val("pool_len", pool_run, delay + 1);
                pool_run = 0;
            end
            if (wr_en) begin
                if (wr_cnt >= NW) begin
                    check_val("wr_extra", 1, 0);
                end else begin
                    check_val("wr_addr", wr_addr, wr_cnt);
                    check_val("wr_data", wr_data, exp_wr_q.pop_front());
                end
                wr_cnt++;
                if (mode == 3 && wr_cnt == tgt + 1) begin
                    rst = 1'b1;
                    #1;
                    check_all_zero("rst_async");
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
            end
            if (done) begin
                done_cnt++;
                check_val("done_cycle", rel, 4 * (7 + delay) + 1);
                @(negedge clk);
                check_val("idle_after_done", busy, 0);
                finished = 1'b1;
                break;
            end
            if (mode == 1 && rel == 9 + delay) start = 1'b1;
            if (mode == 2 && pool_en && wr_cnt == 2) begin
                abort = 1'b1;
                abort_sent = 1'b1;
            end
        end
        check_val("run_finished", finished, 1);
        check_val("done_count", done_cnt, 1);
        check_val("write_count", wr_cnt, NW);
        check_val("busy_cycles", busy_cnt, 4 * (7 + delay) + 1);
        check_val("rd_left", exp_rd_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < NPIX; i++) mem[i] = data_t'(i);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // ramp buffer: writes 0:5 1:7 2:13 3:15, done at cycle 29
        run_map(0, 0, 0);

        // negative window 0
        fill_random();
        mem[0] = -5; mem[1] = -3; mem[4] = -9; mem[5] = -30;
        run_map(0, 0, 0);

        // slow pooling unit
        fill_random();
        run_map(3, 0, 0);

        // stray start while busy
        fill_random();
        run_map(0, 1, 0);

        for (int n = 0; n < 4; n++) begin
            fill_random();
            run_map($urandom_range(0, 4), n % 2, 0);
        end

        // abort then restart from address 0
        fill_random();
        run_map($urandom_range(0, 3), 2, 0);
        run_map(0, 0, 0);

        // async reset during a write, then a full clean run
        fill_random();
        run_map($urandom_range(0, 2), 3, $urandom_range(0, NW - 1));
        run_map(0, 0, 0);

        // start and abort together in IDLE: stays idle
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_val("start_abort_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pool_window_sched.md
Name: pool_window_sched

Overview:
- Sequences the 2x2 max-pooling unit over a whole feature map held in a single-port feature buffer.
- Per window: fetches four operands from the input buffer, presents them to the pooling unit with a handshake, then writes the pooled result to the output buffer.
- Sits between the conv-layer output buffer and the pool-layer output buffer; launched once per channel by the layer sequencer.

Parameters:
- DATA_W, 30, signed operand/result width; matches pooling datapath.
- IN_W, 24, input map width in pixels; must be even and >= 2.
- IN_H, 24, input map height in pixels; must be even and >= 2.
- RA_W, 10, input buffer address width; must hold IN_W*IN_H-1.
- WA_W, 8, output buffer address width; must hold (IN_W/2)*(IN_H/2)-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle launch pulse; ignored unless IDLE.
- abort  in  1  synchronous cancel; returns to IDLE with no done pulse.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last output is written.
- rd_en  out  1  input buffer read strobe.
- rd_addr  out  RA_W  input buffer read address.
- rd_data  in  DATA_W signed  read data, valid exactly 1 cycle after rd_en.
- pool_en  out  1  enable to the pooling unit.
- pool_in0..pool_in3  out  DATA_W signed each  window operands (top-left, top-right, bottom-left, bottom-right).
- pool_out  in  DATA_W signed  pooled max.
- pool_done  in  1  pooling unit result valid.
- wr_en  out  1  output buffer write strobe.
- wr_addr  out  WA_W  output buffer write address.
- wr_data  out  DATA_W signed  value written.

Behaviour:
- Reset: all outputs 0, state IDLE, window counters r=c=0; takes effect immediately, including mid-operation. No done pulse is produced for an interrupted map.
- States:
  - IDLE: on start, go to FETCH with r=c=0, k=0.
  - FETCH (4 cycles, k=0..3): rd_en=1; rd_addr = base + {0, 1, IN_W, IN_W+1}[k], where base = 2r*IN_W + 2c.
  - LAST (1 cycle): rd_en=0; captures the 4th operand.
  - POOL: pool_en=1 while operands are held; wait for pool_done.
  - WRITE (1 cycle): wr_en=1; then go to FETCH for the next window, or to DONE after the last window.
  - DONE (1 cycle): done=1; then go to IDLE.
- Operand capture: rd_data is registered into pool_in[k-1] in the cycle after the read for k; operand 3 is captured in LAST.
- pool_in0..3 are stable for the entire POOL state. They may only change in FETCH/LAST. They are not cleared after WRITE.
- Handshake: pool_en rises on POOL entry. In any POOL cycle where pool_done=1, pool_out is registered into wr_data and the FSM moves to WRITE. pool_en drops on leaving POOL. pool_done outside POOL is ignored. There is no timeout; the FSM waits indefinitely.
- Output address: wr_addr = r*(IN_W/2) + c, presented in WRITE. wr_data holds its value until the next capture.
- Scan order is raster. c increments after each WRITE. When c=IN_W/2-1, c wraps to 0 and r increments. The last window is r=IN_H/2-1, c=IN_W/2-1.
- Timing: with pool_done asserted in the first POOL cycle, one window takes 7 cycles (4 FETCH + LAST + POOL + WRITE). The full map takes 7*(IN_W/2)*(IN_H/2) cycles, plus 1 DONE cycle.
- start while busy: ignored, no effect. start and abort in the same IDLE cycle: abort wins, stay in IDLE.
- abort in any non-IDLE state: next state is IDLE. All strobes (rd_en, pool_en, wr_en, done) are 0 from the next cycle; counters are cleared. A WRITE already in progress completes its single cycle; no further writes occur.
- No arithmetic on data; addresses use unsigned arithmetic wide enough not to overflow at max r and c.

Decomposition:
- Shared package cnn_pkg:
  - DATA_W constant and signed data typedef.
  - State enum (IDLE, FETCH, LAST, POOL, WRITE, DONE).
  - Operand-offset constants for the 2x2 window.
- Natural sub-module pool_addr_gen: holds the r/c/k counters; produces rd_addr, wr_addr and a last_window flag; has clear and advance inputs.

Test Plan:
- IN_W=IN_H=4, buffer = 0..15, pool stub returns max with pool_done the same cycle: rd_addr order 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15. Writes (addr:data) 0:5, 1:7, 2:13, 3:15. done pulses at cycle 29 after start; busy high for cycles 1..29.
- Negative data -5,-3,-9,-30 in window 0; stub returns -3: pool_in0..3 = those values, held stable through POOL; wr_data=-3 at wr_addr 0.
- Stub delays pool_done by 3 cycles: pool_en high for exactly 4 cycles, with no rd_en or wr_en during that time. Per-window time becomes 10 cycles.
- start pulsed again during FETCH of window 1: ignored. Still exactly 4 writes and one done.
- abort during POOL of window 2: from the next cycle busy=0 and pool_en=0, with no done and no further writes. A subsequent start restarts at rd_addr 0.
- rst asserted mid-WRITE asynchronously: all outputs read 0 before the next clock edge. After release, start produces the full correct 4-write sequence.
